// File: rtl/kernel_pool_stream.sv
// Streaming KSIZE x KSIZE window pooling over absolute deviations of neighbouring pixels (max or saturating sum).
// Latency: result registered one clock after the accept that completes a window.
// Backpressure: single output register, no skid; in_ready = !out_valid | out_ready.
// Optional feature macro: KPOOL_VERT_AD_EN adds vertical-pair deviations to the reduction.
module kernel_pool_stream #(
  parameter int DWIDTH = 8,
  parameter int KSIZE  = 3,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_pixel,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NAD_H = KSIZE * (KSIZE - 1);
`ifdef KPOOL_VERT_AD_EN
  localparam int NAD   = 2 * NAD_H;
`else
  localparam int NAD   = NAD_H;
`endif
  // Sum is wide enough to hold every deviation at full scale before clamping.
  localparam int SW    = DWIDTH + $clog2(NAD + 1);

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KSIZE - 1);
  localparam logic [SW-1:0] SAT       = {{(SW-DWIDTH){1'b0}}, {DWIDTH{1'b1}}};

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  // lbuf_q[0] holds the oldest buffered row, lbuf_q[KSIZE-2] the row just above the current one.
  logic [DWIDTH-1:0] lbuf_q [KSIZE-1][IMG_W];
  logic [DWIDTH-1:0] win_q  [KSIZE][KSIZE];
  logic [DWIDTH-1:0] win_d  [KSIZE][KSIZE];

  logic              accept;
  logic              complete;
  logic              frame_end;
  logic [DWIDTH-1:0] max_ad;
  logic [SW-1:0]     sum_ad;
  logic [DWIDTH-1:0] ad;
  logic [DWIDTH-1:0] pool_res;

  function automatic logic [DWIDTH-1:0] absdiff(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign in_ready  = !out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign complete  = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign frame_end = (row_q == ROW_MAX) && (col_q == COL_MAX);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Raster position: column wraps into the next row, last pixel of the frame wraps both.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Next window: shift every row left and bring in the column under the incoming pixel.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < KSIZE - 1; r++) begin
      win_d[r][KSIZE-1] = lbuf_q[r][col_q];
    end
    win_d[KSIZE-1][KSIZE-1] = in_pixel;
  end

  // Reduce all deviations of the window that includes the incoming pixel.
  always_comb begin
    max_ad = '0;
    sum_ad = '0;
    ad     = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        ad = absdiff(win_d[r][c], win_d[r][c+1]);
        if (ad > max_ad) max_ad = ad;
        sum_ad = sum_ad + SW'(ad);
      end
    end
`ifdef KPOOL_VERT_AD_EN
    for (int r = 0; r < KSIZE - 1; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        ad = absdiff(win_d[r][c], win_d[r+1][c]);
        if (ad > max_ad) max_ad = ad;
        sum_ad = sum_ad + SW'(ad);
      end
    end
`endif
    if (mode) begin
      pool_res = (sum_ad > SAT) ? {DWIDTH{1'b1}} : sum_ad[DWIDTH-1:0];
    end else begin
      pool_res = max_ad;
    end
  end

  // Output register: load on a completing accept, otherwise drain when the consumer takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept && complete) begin
      out_valid_d = 1'b1;
      out_data_d  = pool_res;
      out_last_d  = frame_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state with synchronous reset; a reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Pixel storage needs no reset: stale contents are never used before being overwritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  // Line buffers: push the column down one row and store the incoming pixel at the newest row.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KSIZE - 2; r++) begin
        lbuf_q[r][col_q] <= lbuf_q[r+1][col_q];
      end
      lbuf_q[KSIZE-2][col_q] <= in_pixel;
    end
  end

endmodule

// File: doc/kernel_pool_stream.md
Name: kernel_pool_stream

Overview:
Streaming, parametrised successor to the combinational 3x3 kernel-pooling block. Accepts a raster-order pixel stream with a valid/ready handshake and buffers KSIZE-1 image rows in internal line buffers. For every full KSIZE x KSIZE window (stride 1, valid-only, no padding) it computes all horizontal absolute deviations and reduces them to one pooled value. Sits between the pixel source and the feature-map writer in the image pipeline.

Parameters:
DWIDTH, 8, pixel and result width in bits
KSIZE, 3, window edge length; legal range 2..7
IMG_W, 16, pixels per image row; must be >= KSIZE
IMG_H, 16, rows per frame; must be >= KSIZE

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  in_pixel is valid this cycle
in_ready  output  1  block can accept a pixel this cycle
in_pixel  input  DWIDTH  unsigned pixel, raster order
mode  input  1  0 = max of deviations, 1 = saturating sum of deviations
out_valid  output  1  out_data holds a pooled result
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  DWIDTH  pooled window result
out_last  output  1  marks the final window of a frame

Behaviour:
- Reset is synchronous: rst_n sampled low at a rising edge forces out_valid=0, out_data=0, out_last=0, col=0, row=0. Line-buffer contents are don't-care after reset.
- Reset mid-frame abandons the current frame. The next accepted pixel is treated as pixel (0,0).
- in_ready = !out_valid | out_ready, computed combinationally. Accept = in_valid & in_ready.
- Output handshake: out_data and out_last stay stable while out_valid=1 and out_ready=0. The output holds one result in a single register; there is no skid buffer.
- Counters col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accept.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
  - Frames run back-to-back with no gap.
- Window completion: an accepted pixel at (row >= KSIZE-1, col >= KSIZE-1) completes a window. Its bottom-right corner is that pixel.
- Pixel storage: KSIZE-1 line buffers of IMG_W x DWIDTH, plus a KSIZE x KSIZE window register array shifted left on each accept.
- Deviations: AD = |a-b| for horizontally adjacent pairs, giving KSIZE*(KSIZE-1) values per window, each DWIDTH bits wide and exact.
- Reduction:
  - mode=0: maximum AD.
  - mode=1: sum of ADs, clamped to 2^DWIDTH-1.
  - mode is sampled on the accept that completes the window.
- Latency: out_valid rises on the clock edge after the completing accept, i.e. a 1-cycle registered result.
- When out_ready=1 and a new window completes in the same cycle, out_valid stays 1 and the data is replaced with the new result.
- When out_ready=1 and no window completes, out_valid falls to 0.
- out_last=1 with the result of the window whose corner is (IMG_H-1, IMG_W-1).
- Results per frame: (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1).
- Accepts that do not complete a window produce no output.

Optional Feature:
Macro KPOOL_VERT_AD_EN.
- Defined: vertical ADs for vertically adjacent pairs are also computed, adding a further KSIZE*(KSIZE-1) values. Both sets feed the same max/saturating-sum reduction. Latency and the handshake are unchanged.
- Undefined: only horizontal ADs are computed, and no vertical-difference logic is present.

Test Plan:
All scenarios use KSIZE=3, IMG_W=4, IMG_H=4, DWIDTH=8.
- Constant image of all 50s, mode=0, out_ready=1 -> exactly 4 results, all 0; out_last=1 only on the 4th; each result appears 1 cycle after accepting pixels 11, 12, 15 and 16.
- Every row is 0,10,20,30 -> mode=0 gives 10 for all 4 windows; mode=1 gives 60 for all 4 windows.
- Every row is 0,255,0,255 with mode=1 -> 1530 saturates, giving 255 for every window; mode=0 also gives 255.
- out_ready held low from pixel 1 -> after the 11th accept, out_valid=1 and in_ready=0. out_data stays stable for 10 cycles. Raising out_ready for 1 cycle consumes the result and streaming resumes, with no pixel lost or duplicated.
- Reset mid-frame: rst_n=0 for 1 cycle after 7 accepts -> out_valid=0 the next cycle. A fresh frame of 16 pixels then yields 4 results, the first after the 11th pixel of the new frame.
- Vertical deviations, KPOOL_VERT_AD_EN defined: rows are constant 0, 40, 80, 120 with mode=0 -> all results 40. With the macro undefined, the same stimulus gives all results 0.
